// File: rtl/id_stage.sv
// MIPS-subset instruction decode stage with registered valid/ready output bundle.
// Optional EX/MEM operand forwarding is enabled by defining ID_FWD_EN.
module id_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int REG_AW   = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic [31:0]         inst_i,
    output logic                re1_o,
    output logic                re2_o,
    output logic [REG_AW-1:0]   raddr1_o,
    output logic [REG_AW-1:0]   raddr2_o,
    input  logic [DATA_W-1:0]   data1_i,
    input  logic [DATA_W-1:0]   data2_i,
    input  logic                ex_we_i,
    input  logic [REG_AW-1:0]   ex_waddr_i,
    input  logic [DATA_W-1:0]   ex_wdata_i,
    input  logic                ex_is_load_i,
    input  logic                mem_we_i,
    input  logic [REG_AW-1:0]   mem_waddr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   pc_o,
    output logic [ALUOP_W-1:0]  aluop_o,
    output logic [ALUSEL_W-1:0] alusel_o,
    output logic [DATA_W-1:0]   rdata_1_o,
    output logic [DATA_W-1:0]   rdata_2_o,
    output logic [DATA_W-1:0]   store_data_o,
    output logic                we_o,
    output logic [REG_AW-1:0]   waddr_o
);

    localparam logic [ALUSEL_W-1:0] SEL_NOP   = ALUSEL_W'(0);
    localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(1);
    localparam logic [ALUSEL_W-1:0] SEL_ARITH = ALUSEL_W'(4);
    localparam logic [ALUSEL_W-1:0] SEL_LS    = ALUSEL_W'(7);

    localparam logic [ALUOP_W-1:0] OP_AND = ALUOP_W'(8'h24);
    localparam logic [ALUOP_W-1:0] OP_OR  = ALUOP_W'(8'h25);
    localparam logic [ALUOP_W-1:0] OP_XOR = ALUOP_W'(8'h26);
    localparam logic [ALUOP_W-1:0] OP_LW  = ALUOP_W'(8'hE3);
    localparam logic [ALUOP_W-1:0] OP_SW  = ALUOP_W'(8'hEB);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [15:0]       imm;

    assign opcode = inst_i[31:26];
    assign funct  = inst_i[5:0];
    assign rs     = REG_AW'(inst_i[25:21]);
    assign rt     = REG_AW'(inst_i[20:16]);
    assign rd     = REG_AW'(inst_i[15:11]);
    assign imm    = inst_i[15:0];

    logic                unused_shamt;
    assign unused_shamt = ^inst_i[10:6];

    logic                dec_re1;
    logic                dec_re2;
    logic [ALUOP_W-1:0]  dec_aluop;
    logic [ALUSEL_W-1:0] dec_alusel;
    logic                dec_we;
    logic [REG_AW-1:0]   dec_waddr;
    logic                use_imm;
    logic                is_store;
    logic [DATA_W-1:0]   imm_val;

    always_comb begin
        dec_re1    = 1'b0;
        dec_re2    = 1'b0;
        dec_aluop  = '0;
        dec_alusel = SEL_NOP;
        dec_we     = 1'b0;
        dec_waddr  = '0;
        use_imm    = 1'b0;
        is_store   = 1'b0;
        imm_val    = '0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h24, 6'h25, 6'h26, 6'h21, 6'h23: begin
                        dec_re1    = 1'b1;
                        dec_re2    = 1'b1;
                        dec_aluop  = ALUOP_W'(funct);
                        dec_alusel = (funct == 6'h21 || funct == 6'h23) ? SEL_ARITH : SEL_LOGIC;
                        dec_we     = 1'b1;
                        dec_waddr  = rd;
                    end
                    default: ;
                endcase
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dec_re1    = 1'b1;
                dec_aluop  = (opcode == 6'h0C) ? OP_AND : (opcode == 6'h0D) ? OP_OR : OP_XOR;
                dec_alusel = SEL_LOGIC;
                dec_we     = 1'b1;
                dec_waddr  = rt;
                use_imm    = 1'b1;
                imm_val    = {{(DATA_W-16){1'b0}}, imm};
            end
            6'h0F: begin
                dec_aluop  = OP_OR;
                dec_alusel = SEL_LOGIC;
                dec_we     = 1'b1;
                dec_waddr  = rt;
                use_imm    = 1'b1;
                imm_val    = {imm, {(DATA_W-16){1'b0}}};
            end
            6'h23: begin
                dec_re1    = 1'b1;
                dec_aluop  = OP_LW;
                dec_alusel = SEL_LS;
                dec_we     = 1'b1;
                dec_waddr  = rt;
                use_imm    = 1'b1;
                imm_val    = {{(DATA_W-16){imm[15]}}, imm};
            end
            6'h2B: begin
                dec_re1    = 1'b1;
                dec_re2    = 1'b1;
                dec_aluop  = OP_SW;
                dec_alusel = SEL_LS;
                use_imm    = 1'b1;
                is_store   = 1'b1;
                imm_val    = {{(DATA_W-16){imm[15]}}, imm};
            end
            default: ;
        endcase
    end

    assign re1_o    = dec_re1;
    assign re2_o    = dec_re2;
    assign raddr1_o = rs;
    assign raddr2_o = rt;

`ifdef ID_FWD_EN
    // A load in EX has no data yet, so only non-load EX results are forwarded.
    function automatic logic [DATA_W-1:0] src_val(input logic [REG_AW-1:0] addr,
                                                  input logic [DATA_W-1:0] rf);
        if (addr == '0)
            return '0;
        else if (ex_we_i && !ex_is_load_i && ex_waddr_i == addr)
            return ex_wdata_i;
        else if (mem_we_i && mem_waddr_i == addr)
            return mem_wdata_i;
        else
            return rf;
    endfunction

    function automatic logic src_hazard(input logic [REG_AW-1:0] addr);
        return (addr != '0) && ex_we_i && ex_is_load_i && (ex_waddr_i == addr);
    endfunction
`else
    function automatic logic [DATA_W-1:0] src_val(input logic [REG_AW-1:0] addr,
                                                  input logic [DATA_W-1:0] rf);
        return (addr == '0) ? '0 : rf;
    endfunction

    // Without forwarding, any pending write to a source must retire first.
    function automatic logic src_hazard(input logic [REG_AW-1:0] addr);
        return (addr != '0) &&
               ((ex_we_i && ex_waddr_i == addr) || (mem_we_i && mem_waddr_i == addr));
    endfunction

    logic unused_fwd;
    assign unused_fwd = ^{ex_is_load_i, ex_wdata_i, mem_wdata_i};
`endif

    logic              hazard;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] sdata;

    assign hazard = (dec_re1 && src_hazard(rs)) || (dec_re2 && src_hazard(rt));
    assign src1   = dec_re1 ? src_val(rs, data1_i) : '0;
    assign src2   = dec_re2 ? src_val(rt, data2_i) : '0;
    assign op1    = src1;
    assign op2    = use_imm ? imm_val : src2;
    assign sdata  = is_store ? src2 : '0;

    assign in_ready = ((!out_valid) || out_ready) && !hazard && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            pc_o         <= '0;
            aluop_o      <= '0;
            alusel_o     <= '0;
            rdata_1_o    <= '0;
            rdata_2_o    <= '0;
            store_data_o <= '0;
            we_o         <= 1'b0;
            waddr_o      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid    <= 1'b1;
            pc_o         <= pc_i;
            aluop_o      <= dec_aluop;
            alusel_o     <= dec_alusel;
            rdata_1_o    <= op1;
            rdata_2_o    <= op2;
            store_data_o <= sdata;
            we_o         <= dec_we;
            waddr_o      <= dec_waddr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed stimulus pushes expected bundles, a monitor pops on consume.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        re1_o, re2_o;
    logic [4:0]  raddr1_o, raddr2_o;
    logic [31:0] data1_i, data2_i;
    logic        ex_we_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_is_load_i;
    logic        mem_we_i;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_o;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
    logic [31:0] rdata_1_o, rdata_2_o, store_data_o;
    logic        we_o;
    logic [4:0]  waddr_o;

    id_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .inst_i(inst_i),
        .re1_o(re1_o), .re2_o(re2_o),
        .raddr1_o(raddr1_o), .raddr2_o(raddr2_o),
        .data1_i(data1_i), .data2_i(data2_i),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i),
        .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
        .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
        .rdata_1_o(rdata_1_o), .rdata_2_o(rdata_2_o), .store_data_o(store_data_o),
        .we_o(we_o), .waddr_o(waddr_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] sd;
        logic        we;
        logic [4:0]  waddr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t nop_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] pc, input logic [7:0] aluop,
                                input logic [2:0] alusel, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [31:0] sd,
                                input logic we, input logic [4:0] waddr);
        exp_t e;
        e.pc = pc; e.aluop = aluop; e.alusel = alusel; e.r1 = r1;
        e.r2 = r2; e.sd = sd; e.we = we; e.waddr = waddr;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clearSide();
        ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
        mem_we_i = 0; mem_waddr_i = 0; mem_wdata_i = 0;
        data1_i = 0; data2_i = 0;
    endtask

    // Present one instruction for one cycle; expected bundle is queued only if acceptance is expected.
    task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] pc,
                                 input logic exp_ready, input logic exp_re1,
                                 input logic exp_re2, input exp_t e);
        inst_i = inst; pc_i = pc; in_valid = 1'b1;
        #1;
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
        checkOutput("re1", 32'(re1_o), 32'(exp_re1));
        checkOutput("re2", 32'(re2_o), 32'(exp_re2));
        if (exp_ready) exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0; inst_i = 32'h0;
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_output_pc", pc_o, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("bundle.pc", pc_o, mon_e.pc);
                checkOutput("bundle.aluop", 32'(aluop_o), 32'(mon_e.aluop));
                checkOutput("bundle.alusel", 32'(alusel_o), 32'(mon_e.alusel));
                checkOutput("bundle.rdata_1", rdata_1_o, mon_e.r1);
                checkOutput("bundle.rdata_2", rdata_2_o, mon_e.r2);
                checkOutput("bundle.store_data", store_data_o, mon_e.sd);
                checkOutput("bundle.we", 32'(we_o), 32'(mon_e.we));
                checkOutput("bundle.waddr", 32'(waddr_o), 32'(mon_e.waddr));
            end
        end
    end

    initial begin
        nop_e = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 0; flush = 0; in_valid = 0; out_ready = 1;
        pc_i = 0; inst_i = 0;
        clearSide();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.out_valid", 32'(out_valid), 0);
        checkOutput("reset.pc", pc_o, 0);
        checkOutput("reset.aluop", 32'(aluop_o), 0);
        checkOutput("reset.we", 32'(we_o), 0);
        checkOutput("reset.rdata_2", rdata_2_o, 0);
        rst = 1;

        // ORI $1,$0,0x8000 with a bogus $0 writer in EX and garbage regfile data
        ex_we_i = 1; ex_waddr_i = 0; ex_wdata_i = 32'hDEAD; data1_i = 32'h55;
        applyStimulus(32'h34018000, 32'h0040_0000, 1, 1, 0,
                      mk(32'h0040_0000, 8'h25, 3'd1, 32'h0, 32'h0000_8000, 0, 1, 5'd1));
        clearSide();

        // LUI $2,0x1234
        applyStimulus(32'h3C021234, 32'h0040_0004, 1, 0, 0,
                      mk(32'h0040_0004, 8'h25, 3'd1, 32'h0, 32'h1234_0000, 0, 1, 5'd2));

        // ADDU $3,$1,$2 with EX writing $1=5 and MEM writing $2=7
        ex_we_i = 1; ex_waddr_i = 1; ex_wdata_i = 5;
        mem_we_i = 1; mem_waddr_i = 2; mem_wdata_i = 7;
`ifdef ID_FWD_EN
        applyStimulus(32'h00221821, 32'h0040_0008, 1, 1, 1,
                      mk(32'h0040_0008, 8'h21, 3'd4, 32'd5, 32'd7, 0, 1, 5'd3));
`else
        applyStimulus(32'h00221821, 32'h0040_0008, 0, 1, 1, nop_e);
        clearSide();
        data1_i = 5; data2_i = 7;
        applyStimulus(32'h00221821, 32'h0040_0008, 1, 1, 1,
                      mk(32'h0040_0008, 8'h21, 3'd4, 32'd5, 32'd7, 0, 1, 5'd3));
`endif
        clearSide();

        // Back-to-back LW, SW, AND, ANDI at full throughput
        data1_i = 32'h100;
        applyStimulus(32'h8C24FFF0, 32'h0040_000C, 1, 1, 0,
                      mk(32'h0040_000C, 8'hE3, 3'd7, 32'h100, 32'hFFFF_FFF0, 0, 1, 5'd4));
        data1_i = 32'h200; data2_i = 32'hABCD;
        applyStimulus(32'hAC24FFFC, 32'h0040_0010, 1, 1, 1,
                      mk(32'h0040_0010, 8'hEB, 3'd7, 32'h200, 32'hFFFF_FFFC, 32'hABCD, 0, 5'd0));
        data1_i = 32'hF0F0; data2_i = 32'hFF00;
        applyStimulus(32'h00223824, 32'h0040_0014, 1, 1, 1,
                      mk(32'h0040_0014, 8'h24, 3'd1, 32'hF0F0, 32'hFF00, 0, 1, 5'd7));
        data1_i = 32'h1234; data2_i = 32'h0;
        applyStimulus(32'h30288001, 32'h0040_0018, 1, 1, 0,
                      mk(32'h0040_0018, 8'h24, 3'd1, 32'h1234, 32'h0000_8001, 0, 1, 5'd8));
        clearSide();

        // Load-use: LW $4 in EX, SUBU $5,$4,$4 must stall and leave a bubble
        ex_we_i = 1; ex_is_load_i = 1; ex_waddr_i = 4; ex_wdata_i = 32'hBAD;
        applyStimulus(32'h00842823, 32'h0040_001C, 0, 1, 1, nop_e);
        checkOutput("loaduse.bubble", 32'(out_valid), 0);
        clearSide();
        mem_we_i = 1; mem_waddr_i = 4; mem_wdata_i = 32'h99;
`ifdef ID_FWD_EN
        applyStimulus(32'h00842823, 32'h0040_001C, 1, 1, 1,
                      mk(32'h0040_001C, 8'h23, 3'd4, 32'h99, 32'h99, 0, 1, 5'd5));
`else
        applyStimulus(32'h00842823, 32'h0040_001C, 0, 1, 1, nop_e);
        clearSide();
        data1_i = 32'h99; data2_i = 32'h99;
        applyStimulus(32'h00842823, 32'h0040_001C, 1, 1, 1,
                      mk(32'h0040_001C, 8'h23, 3'd4, 32'h99, 32'h99, 0, 1, 5'd5));
`endif
        clearSide();

        // XORI $6,$1,0xFF, then hold for 3 cycles while another instruction waits, then flush
        data1_i = 32'h0F0F;
        applyStimulus(32'h382600FF, 32'h0040_0020, 1, 1, 0,
                      mk(32'h0040_0020, 8'h26, 3'd1, 32'h0F0F, 32'h0000_00FF, 0, 1, 5'd6));
        clearSide();
        out_ready = 0;
        inst_i = 32'h34018000; pc_i = 32'h0040_0024; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("hold.in_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
            checkOutput("hold.out_valid", 32'(out_valid), 1);
            checkOutput("hold.pc", pc_o, 32'h0040_0020);
            checkOutput("hold.rdata_2", rdata_2_o, 32'h0000_00FF);
        end
        flush = 1;
        #1;
        checkOutput("flush.in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        checkOutput("flush.out_valid", 32'(out_valid), 0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        flush = 0; in_valid = 0; inst_i = 0; out_ready = 1;

        // Undecoded opcode 0x3F becomes a NOP; reset mid-hold drops it asynchronously
        applyStimulus(32'hFC000000, 32'h0040_0028, 1, 0, 0,
                      mk(32'h0040_0028, 8'h00, 3'd0, 0, 0, 0, 0, 5'd0));
        out_ready = 0;
        checkOutput("nop.out_valid", 32'(out_valid), 1);
        checkOutput("nop.pc", pc_o, 32'h0040_0028);
        checkOutput("nop.aluop", 32'(aluop_o), 0);
        checkOutput("nop.alusel", 32'(alusel_o), 0);
        checkOutput("nop.we", 32'(we_o), 0);
        @(posedge clk); #2;
        checkOutput("nop.held", 32'(out_valid), 1);
        rst = 0;
        #1;
        checkOutput("async_reset.out_valid", 32'(out_valid), 0);
        checkOutput("async_reset.pc", pc_o, 0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(posedge clk); #1;
        rst = 1; out_ready = 1;

        // Operation resumes after reset release
        data2_i = 32'h0;
        applyStimulus(32'h3C02ABCD, 32'h0040_002C, 1, 0, 0,
                      mk(32'h0040_002C, 8'h25, 3'd1, 32'h0, 32'hABCD_0000, 0, 1, 5'd2));

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
